// File: rtl/cacheline_arbiter_if.sv
// Shared-cacheline port bundle: I-cache and D-cache requester sides plus the memory side.
// The arbiter takes the slave view; the environment (caches + memory) takes the master view.
interface cacheline_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);
    logic                  icache_read;
    logic [ADDR_WIDTH-1:0] icache_address;
    logic [LINE_WIDTH-1:0] icache_rdata;
    logic                  icache_resp;

    logic                  dcache_read;
    logic                  dcache_write;
    logic [ADDR_WIDTH-1:0] dcache_address;
    logic [LINE_WIDTH-1:0] dcache_wdata;
    logic [LINE_WIDTH-1:0] dcache_rdata;
    logic                  dcache_resp;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic [LINE_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport slave (
        input  icache_read, icache_address,
        output icache_rdata, icache_resp,
        input  dcache_read, dcache_write, dcache_address, dcache_wdata,
        output dcache_rdata, dcache_resp,
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output icache_read, icache_address,
        input  icache_rdata, icache_resp,
        output dcache_read, dcache_write, dcache_address, dcache_wdata,
        input  dcache_rdata, dcache_resp,
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between the I-cache and D-cache.
// The winning request is latched and held on the memory side until mem_resp.
module cacheline_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                clk,
    input  logic                rst,
    cacheline_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [LINE_WIDTH-1:0] req_wdata_q, req_wdata_d;
    logic                  req_write_q, req_write_d;
    logic                  pend_i, pend_d, grant_i, grant_d;
    logic                  serving;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_D;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_write_q  <= req_write_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_write_d  = req_write_q;

        pend_i  = bus.icache_read;
        pend_d  = bus.dcache_read | bus.dcache_write;
        // On a tie, the requester that did not win last time goes first.
        grant_i = pend_i && (!pend_d || (last_grant_q == GRANT_D));
        grant_d = pend_d && !grant_i;

        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d      = SERVE_I;
                    last_grant_d = GRANT_I;
                    req_addr_d   = bus.icache_address;
                    req_wdata_d  = '0;
                    req_write_d  = 1'b0;
                end else if (grant_d) begin
                    state_d      = SERVE_D;
                    last_grant_d = GRANT_D;
                    req_addr_d   = bus.dcache_address;
                    req_wdata_d  = bus.dcache_wdata;
                    // Read and write together is treated as a write.
                    req_write_d  = bus.dcache_write;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.mem_resp) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory side comes only from registered state, never from requester inputs.
    assign serving         = (state_q == SERVE_I) || (state_q == SERVE_D);
    assign bus.mem_read    = serving && !req_write_q;
    assign bus.mem_write   = serving && req_write_q;
    assign bus.mem_address = req_addr_q;
    assign bus.mem_wdata   = req_wdata_q;

    assign bus.icache_resp  = (state_q == SERVE_I) && bus.mem_resp;
    assign bus.dcache_resp  = (state_q == SERVE_D) && bus.mem_resp;
    assign bus.icache_rdata = bus.icache_resp ? bus.mem_rdata : '0;
    assign bus.dcache_rdata = bus.dcache_resp ? bus.mem_rdata : '0;

endmodule

// File: doc/cacheline_arbiter.md
# cacheline_arbiter

Arbitrates between the instruction cache and the data cache for the single shared cacheline port to physical memory. Sits below both caches and above the memory/burst interface. Latches the winning request and holds it stable on the memory side until `mem_resp`, then routes the response to the granted cache. Uses round-robin priority so that neither fetch misses nor load/store misses can starve.

## Interface
Parameters:
- ADDR_WIDTH, 32, cacheline address width (byte address, line-aligned by requester)
- LINE_WIDTH, 256, cacheline data width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  synchronous active-high reset
- icache_read  in  1  I-cache line fill request; held until icache_resp
- icache_address  in  ADDR_WIDTH  I-cache line address
- icache_rdata  out  LINE_WIDTH  fill data, valid when icache_resp=1
- icache_resp  out  1  one-cycle completion pulse to I-cache
- dcache_read  in  1  D-cache line fill request; held until dcache_resp
- dcache_write  in  1  D-cache writeback request; held until dcache_resp
- dcache_address  in  ADDR_WIDTH  D-cache line address
- dcache_wdata  in  LINE_WIDTH  writeback data
- dcache_rdata  out  LINE_WIDTH  fill data, valid when dcache_resp=1
- dcache_resp  out  1  one-cycle completion pulse to D-cache
- mem_read  out  1  read request to memory
- mem_write  out  1  write request to memory
- mem_address  out  ADDR_WIDTH  latched request address
- mem_wdata  out  LINE_WIDTH  latched writeback data
- mem_rdata  in  LINE_WIDTH  memory read data, valid with mem_resp
- mem_resp  in  1  one-cycle completion from memory

## Operation
- States: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE: compute pending_i = icache_read, pending_d = dcache_read | dcache_write.
  - Only one pending: grant it.
  - Both pending: grant the requester not granted most recently (last_grant register; reset value = D, so I-cache wins first tie).
  - On grant: latch address, op (read/write) and wdata into request registers; go to SERVE_I or SERVE_D; update last_grant.
- SERVE_x: drive mem_read/mem_write/mem_address/mem_wdata from the latched registers only. Requester inputs are ignored in this state. On mem_resp=1:
  - assert x_resp for that same cycle;
  - drive x_rdata = mem_rdata combinationally;
  - go to DONE.
- DONE: one dead cycle with all mem_* requests deasserted. This lets the requester drop its request after resp, so the same request is not re-sampled. Then go to IDLE.
- dcache_read and dcache_write both high is illegal. Arbiter treats it as a write (write wins).
- A requester that drops its request while in SERVE does not cancel the transaction. The memory access completes, and the resp pulse is still issued.
- The non-granted cache's resp is always 0. Its rdata output is don't-care and is driven 0.
- Reset (at any time, including mid-SERVE):
  - state=IDLE, last_grant=D, latched registers=0;
  - mem_read=mem_write=0, both resp=0, rdata outputs=0.
  - An in-flight memory transaction is abandoned; memory is reset by the same rst.

## Timing
- Request-to-memory latency: request seen in IDLE at cycle N; mem_read/mem_write asserted from cycle N+1.
- mem_* outputs are stable (registered) from grant until the mem_resp cycle inclusive. They deassert in the cycle after mem_resp.
- Resp latency: x_resp is asserted in the same cycle as mem_resp (combinational passthrough). x_resp is exactly one cycle wide.
- Turnaround: minimum 2 cycles between mem_resp and the next mem request (DONE, then IDLE re-arbitration).
- With both requesters streaming back-to-back, grants strictly alternate I, D, I, D…
- No combinational path exists from the icache_*/dcache_* inputs to the mem_* outputs.

## Test plan
- Single I-fill:
  - Stimulus: icache_read=1, address 0x0000_0040; memory responds 3 cycles after mem_read with rdata=0xA5…A5.
  - Required: mem_read rises 1 cycle after the request; mem_address=0x40; icache_resp pulses once with rdata=0xA5…A5; dcache_resp stays 0.
- D writeback:
  - Stimulus: dcache_write=1, address 0x0000_1000, wdata=0x1234…
  - Required: mem_write=1, mem_wdata=0x1234…; dcache_resp pulses in the mem_resp cycle; mem_read never asserts.
- Simultaneous requests after reset:
  - Stimulus: icache_read and dcache_read both raised in the same cycle.
  - Required: I served first. D is granted in the IDLE following I's DONE. The next tie goes to I again.
- Requester change mid-transaction:
  - Stimulus: during SERVE_D, dcache_address changes from 0x200 to 0x300.
  - Required: mem_address stays 0x200 until mem_resp.
- Reset mid-operation:
  - Stimulus: rst asserted during SERVE_I before mem_resp.
  - Required: next cycle mem_read=0, icache_resp=0, state IDLE, last_grant=D. A fresh icache_read is granted normally.
- Illegal D read+write:
  - Stimulus: dcache_read=dcache_write=1.
  - Required: the transaction is issued as mem_write=1 with mem_read=0.
